// File: rtl/wb_stage.sv
// Writeback stage: MEM->WB handshake, load response alignment/extension, register-file write port.
// Optional forwarding outputs enabled by defining WB_BYPASS_EN; otherwise all byp_* are tied low.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_we,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_data,
  output logic        busy,
  output logic        err,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data,
  output logic        byp_pend,
  output logic [4:0]  byp_pend_rd
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN, COMMIT} state_t;

  state_t      state;
  logic [4:0]  rd_q;
  logic        rd_we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        accept;
  logic [31:0] acc_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;
  logic        ld_err;

  // rst_n gates in_ready so the stage never advertises space while held in reset
  assign in_ready = rst_n && !flush && ((state == IDLE) || (state == COMMIT));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign acc_data = (in_wb_sel == 2'd2) ? in_pc4 : in_alu;

  always_comb begin
    lane_b  = '0;
    lane_h  = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    ld_err  = 1'b0;
    case (addr_lo_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    case (funct3_q)
      3'd0: ld_data = {{24{lane_b[7]}}, lane_b};
      3'd4: ld_data = {24'd0, lane_b};
      3'd1: begin
        ld_data = {{16{lane_h[15]}}, lane_h};
        ld_err  = addr_lo_q[0];
      end
      3'd5: begin
        ld_data = {16'd0, lane_h};
        ld_err  = addr_lo_q[0];
      end
      3'd2:    ld_data = mem_rdata;
      default: begin
        ld_data = mem_rdata;
        ld_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      rf_we     <= 1'b0;
      rf_wn     <= '0;
      rf_data   <= '0;
      err       <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (mem_rvalid)
            err <= 1'b1;
          if (accept) begin
            rd_q    <= in_rd;
            rd_we_q <= in_rd_we;
            if (in_wb_sel == 2'd1) begin
              funct3_q  <= in_funct3;
              addr_lo_q <= in_addr_lo;
              state     <= WAIT_LOAD;
            end else begin
              rf_we   <= in_rd_we && (in_rd != 5'd0);
              rf_wn   <= in_rd;
              rf_data <= acc_data;
              if (in_wb_sel == 2'd3)
                err <= 1'b1;
              state <= COMMIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_LOAD: begin
          // a response arriving together with flush is consumed here, so no DRAIN is needed
          if (flush) begin
            state <= mem_rvalid ? IDLE : DRAIN;
          end else if (mem_rvalid) begin
            rf_we   <= rd_we_q && (rd_q != 5'd0);
            rf_wn   <= rd_q;
            rf_data <= ld_data;
            if (ld_err)
              err <= 1'b1;
            state <= COMMIT;
          end
        end
        DRAIN: begin
          if (mem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid   = rf_we;
  assign byp_rd      = rf_wn;
  assign byp_data    = rf_data;
  assign byp_pend    = (state == WAIT_LOAD) && rd_we_q && (rd_q != 5'd0);
  assign byp_pend_rd = byp_pend ? rd_q : 5'd0;
`else
  assign byp_valid   = 1'b0;
  assign byp_rd      = '0;
  assign byp_data    = '0;
  assign byp_pend    = 1'b0;
  assign byp_pend_rd = '0;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on posedge; one clock only.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid in 1, in_ready out 1  MEM->WB handshake; transfer when both high on a posedge.
REQ-004 SHALL have: in_rd in 5 dest reg; in_rd_we in 1 write request; in_wb_sel in 2 (0=ALU, 1=LOAD, 2=PC+4, 3=reserved); in_alu in 32; in_pc4 in 32.
REQ-005 SHALL have: in_funct3 in 3 load width; in_addr_lo in 2 load byte offset.
REQ-006 SHALL have: mem_rvalid in 1, mem_rdata in 32  load response, single-cycle pulse, variable latency.
REQ-007 SHALL have: flush in 1  synchronous kill of the in-flight load and of the current input.
REQ-008 SHALL have: rf_we out 1, rf_wn out 5, rf_data out 32  drive the register file write port (file samples on negedge of the same cycle).
REQ-009 SHALL have: busy out 1 (state != IDLE); err out 1 sticky protocol/format error.
REQ-010 SHALL have: byp_valid out 1, byp_rd out 5, byp_data out 32, byp_pend out 1, byp_pend_rd out 5  forwarding to decode.

Function
REQ-011 SHALL implement states IDLE, WAIT_LOAD, DRAIN, COMMIT.
REQ-012 in_ready SHALL be 1 in IDLE and COMMIT, 0 in WAIT_LOAD and DRAIN, and 0 in any cycle flush=1.
REQ-013 On accept with wb_sel 0/2/3: latch rd, rd_we, data (ALU; PC+4; reserved -> ALU value, err set); next state COMMIT.
REQ-014 On accept with wb_sel=1: latch rd, rd_we, funct3, addr_lo; next state WAIT_LOAD.
REQ-015 WAIT_LOAD: on mem_rvalid latch extended mem_rdata, go COMMIT; else hold indefinitely.
REQ-016 Extension: LB/LBU (0/4) byte at addr_lo*8, sign/zero to 32; LH/LHU (1/5) halfword at addr_lo[1]*16; LW (2) unchanged; funct3 3/6/7 treated as LW with err set; LH/LHU with addr_lo[0]=1 sets err, data still from addr_lo[1] lane.
REQ-017 COMMIT lasts exactly one cycle: rf_we = rd_we && rd!=0, rf_wn = rd, rf_data = latched data; rf_we SHALL be 0 in every other state.
REQ-018 COMMIT with a new accept goes to COMMIT/WAIT_LOAD per REQ-013/014, else IDLE; non-load throughput one per cycle.
REQ-019 Latency: non-load accepted cycle N -> rf_we in cycle N+1; load response in cycle M -> rf_we in M+1.
REQ-020 flush in WAIT_LOAD: go DRAIN, no commit; same cycle as mem_rvalid: response discarded, go IDLE.
REQ-021 DRAIN: wait for mem_rvalid, discard it, go IDLE; flush in DRAIN has no extra effect.
REQ-022 flush in IDLE/COMMIT: current COMMIT still writes; input that cycle not accepted.
REQ-023 mem_rvalid in IDLE or COMMIT SHALL be ignored and set err.
REQ-024 err SHALL stay 1 until reset.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, rf_we=0, rf_wn=0, rf_data=0, err=0, all byp_* =0, busy=0, regardless of clk.
REQ-026 Reset mid-WAIT_LOAD SHALL drop the load; a later mem_rvalid SHALL be treated per REQ-023.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.

Configuration
REQ-028 Macro WB_BYPASS_EN defined: byp_valid/byp_rd/byp_data mirror rf_we/rf_wn/rf_data; byp_pend=1 with byp_pend_rd=rd while in WAIT_LOAD and rd_we && rd!=0.
REQ-029 WB_BYPASS_EN undefined: all byp_* ports present but tied 0; other behaviour identical.

Verification
REQ-030 ALU op rd=5, alu=0x12345678 accepted cycle 0 -> cycle 1 rf_we=1, rf_wn=5, rf_data=0x12345678; cycle 2 rf_we=0.
REQ-031 LB addr_lo=3, mem_rdata=0x80FF_0000 returned 4 cycles later -> rf_data=0xFFFF_FF80 one cycle after mem_rvalid; LBU same -> 0x0000_0080.
REQ-032 Back-to-back: ALU rd=1, PC+4 rd=2, ALU rd=0 on consecutive cycles -> rf_we 1,1,0 on cycles 1-3, in_ready held 1.
REQ-033 Load rd=7, flush 2 cycles later, mem_rvalid 3 cycles after that -> no rf_we, in_ready 0 until cycle after mem_rvalid, err=0.
REQ-034 rst_n pulsed low mid-WAIT_LOAD then mem_rvalid -> outputs 0 during reset, no write, err=1 after stray response.
REQ-035 With WB_BYPASS_EN: load rd=9 pending -> byp_pend=1, byp_pend_rd=9; without macro all byp_* remain 0.
